// File: rtl/tag_match_cache_if.sv
// Handshake bundle for tag_match_cache: insert, lookup, result, flush and occupancy.
// The slave modport is the cache side; the master modport is the requester/consumer side.
interface tag_match_cache_if #(
  parameter int unsigned TAG_W = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned IW = $clog2(DEPTH);

  logic             ins_valid;
  logic [TAG_W-1:0] ins_tag;
  logic             ins_ready;
  logic             lkp_valid;
  logic [TAG_W-1:0] lkp_tag;
  logic             lkp_ready;
  logic             res_valid;
  logic             res_hit;
  logic [IW-1:0]    res_idx;
  logic             res_ready;
  logic             flush;
  logic [IW:0]      count;

  modport master (
    output ins_valid, ins_tag, lkp_valid, lkp_tag, res_ready, flush,
    input  ins_ready, lkp_ready, res_valid, res_hit, res_idx, count
  );

  modport slave (
    input  ins_valid, ins_tag, lkp_valid, lkp_tag, res_ready, flush,
    output ins_ready, lkp_ready, res_valid, res_hit, res_idx, count
  );
endinterface

// File: rtl/tag_match_cache.sv
// Fully-associative tag store with FIFO replacement, duplicate suppression, flush,
// and a one-entry registered lookup result stage with backpressure.
module tag_match_cache #(
  parameter int unsigned TAG_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  tag_match_cache_if.slave  bus
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [IW:0] CountMax = (IW + 1)'(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [IW-1:0]    wr_ptr_q;
  logic [IW:0]      count_q;
  logic             res_valid_q;
  logic             res_hit_q;
  logic [IW-1:0]    res_idx_q;

  logic          ins_fire;
  logic          lkp_fire;
  logic          ins_dup;
  logic          lkp_hit;
  logic [IW-1:0] lkp_idx;

  assign bus.ins_ready = ~bus.flush;
  assign bus.lkp_ready = ~res_valid_q | bus.res_ready;
  assign ins_fire      = bus.ins_valid & bus.ins_ready;
  assign lkp_fire      = bus.lkp_valid & bus.lkp_ready;

  assign bus.res_valid = res_valid_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.count     = count_q;

  // Scan high-to-low so the last assignment leaves the lowest matching index.
  always_comb begin
    lkp_hit = 1'b0;
    lkp_idx = '0;
    ins_dup = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == bus.lkp_tag)) begin
        lkp_hit = 1'b1;
        lkp_idx = IW'(i);
      end
      if (valid_q[i] && (tag_q[i] == bus.ins_tag)) begin
        ins_dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (ins_fire && !ins_dup) begin
      valid_q[wr_ptr_q] <= 1'b1;
      wr_ptr_q          <= wr_ptr_q + 1'b1;
      if (count_q != CountMax) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Tag payload needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (ins_fire && !ins_dup) begin
      tag_q[wr_ptr_q] <= bus.ins_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
    end else if (lkp_fire) begin
      res_valid_q <= 1'b1;
      res_hit_q   <= lkp_hit;
      res_idx_q   <= lkp_idx;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tag_match_cache.sv
// Self-checking bench for tag_match_cache: directed scenarios then randomized traffic,
// compared against a behavioural model of the tag store and result stage.
module tb_tag_match_cache;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tag_match_cache_if #(.TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

  tag_match_cache #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: slot of the k-th accepted new tag since flush is k mod DEPTH.
  bit         m_val [DEPTH];
  logic [7:0] m_tag [DEPTH];
  int         m_ins;
  bit         m_res_valid;
  bit         m_res_hit;
  int         m_res_idx;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    return (m_ins < int'(DEPTH)) ? m_ins : int'(DEPTH);
  endfunction

  task automatic m_find(input logic [7:0] t, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!hit && m_val[i] && m_tag[i] == t) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_val[i] = 1'b0;
    m_ins = 0;
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".res_valid"}, int'(bus.res_valid), int'(m_res_valid));
    check_eq({where, ".res_hit"}, int'(bus.res_hit), int'(m_res_hit));
    check_eq({where, ".res_idx"}, int'(bus.res_idx), m_res_idx);
    check_eq({where, ".count"}, int'(bus.count), m_count());
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.ins_valid = 1'b0;
    bus.lkp_valid = 1'b0;
    bus.ins_tag   = '0;
    bus.lkp_tag   = '0;
    bus.res_ready = 1'b1;
    bus.flush     = 1'b0;
    @(posedge clk);
    m_clear();
    m_res_valid = 1'b0;
    m_res_hit   = 1'b0;
    m_res_idx   = 0;
    #1;
    rst_n = 1'b1;
    #1;
    check_outputs("reset");
    check_eq("reset.ins_ready", int'(bus.ins_ready), 1);
    check_eq("reset.lkp_ready", int'(bus.lkp_ready), 1);
  endtask

  // One clock cycle: drive, check readies, advance model at the edge, check outputs.
  task automatic step(input bit iv, input logic [7:0] it, input bit lv, input logic [7:0] lt,
                      input bit rr, input bit fl);
    bit ifire, lfire, dup, hit;
    int didx, hidx;
    bus.ins_valid = iv;
    bus.ins_tag   = it;
    bus.lkp_valid = lv;
    bus.lkp_tag   = lt;
    bus.res_ready = rr;
    bus.flush     = fl;
    #1;
    check_eq("ins_ready", int'(bus.ins_ready), int'(!fl));
    check_eq("lkp_ready", int'(bus.lkp_ready), int'(!m_res_valid || rr));
    ifire = iv && !fl;
    lfire = lv && (!m_res_valid || rr);
    m_find(lt, hit, hidx);
    m_find(it, dup, didx);
    @(posedge clk);
    if (fl) begin
      m_clear();
    end else if (ifire && !dup) begin
      m_val[m_ins % int'(DEPTH)] = 1'b1;
      m_tag[m_ins % int'(DEPTH)] = it;
      m_ins++;
    end
    if (lfire) begin
      m_res_valid = 1'b1;
      m_res_hit   = hit;
      m_res_idx   = hidx;
    end else if (rr) begin
      m_res_valid = 1'b0;
    end
    #1;
    check_outputs("step");
  endtask

  task automatic ins(input logic [7:0] t);
    step(1'b1, t, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic lkp(input logic [7:0] t);
    step(1'b0, 8'h00, 1'b1, t, 1'b1, 1'b0);
  endtask

  initial begin
    do_reset();

    // Empty store lookup.
    lkp(8'h00);
    check_eq("empty.hit", int'(bus.res_hit), 0);

    // Fill and hit, then duplicate insert.
    ins(8'h11); ins(8'h22); ins(8'h33);
    lkp(8'h22);
    check_eq("hit22.idx", int'(bus.res_idx), 1);
    ins(8'h22);
    check_eq("dup.count", int'(bus.count), 3);

    // Overflow with FIFO replacement.
    ins(8'h11); ins(8'h22); ins(8'h33); ins(8'h44); ins(8'h55);
    check_eq("full.count", int'(bus.count), 4);
    lkp(8'h11);
    check_eq("evicted.hit", int'(bus.res_hit), 0);
    lkp(8'h55);
    check_eq("wrap.idx", int'(bus.res_idx), 0);

    // Same-cycle insert and lookup of one tag.
    step(1'b1, 8'h77, 1'b1, 8'h77, 1'b1, 1'b0);
    check_eq("samecyc.hit", int'(bus.res_hit), 0);
    lkp(8'h77);
    check_eq("after.hit", int'(bus.res_hit), 1);

    // Backpressure hold, then release with a new lookup accepted that cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0);

    // Flush beats a simultaneous insert.
    step(1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("flush.count", int'(bus.count), 0);
    lkp(8'h99);
    check_eq("flush.hit", int'(bus.res_hit), 0);

    // Reset with a pending result.
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    do_reset();

    // Randomized traffic over a small tag pool to exercise hits and duplicates.
    for (int n = 0; n < 600; n++) begin
      if ((n % 200) == 199) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7) * 17),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 7) * 17),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
